// File: rtl/fifo_rd_port_if.sv
// Valid/ready stream carrying words from the read-side output buffer to the consumer.
interface fifo_rd_port_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/fifo_rd_port.sv
// Async FIFO read-side controller: write-pointer sync, read pointers, empty, and a
// 2-entry prefetch buffer presented as a valid/ready stream.
module fifo_rd_port #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 4
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [PTR_WIDTH:0]    g_wptr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [PTR_WIDTH:0]    b_rptr,
  output logic [PTR_WIDTH:0]    g_rptr,
  output logic                  empty,
  output logic                  r_en,
  fifo_rd_port_if.master        m,
  output logic [PTR_WIDTH:0]    rd_level
);

  localparam int unsigned PW = PTR_WIDTH + 1;

  if (DEPTH != (1 << PTR_WIDTH)) begin : g_depth_check
    $error("fifo_rd_port: DEPTH must equal 2**PTR_WIDTH");
  end

  logic [PW-1:0]                   wq1_q, wq2_q;
  logic [PW-1:0]                   wptr_bin;
  logic [PW-1:0]                   b_rptr_d, g_rptr_d;
  logic [1:0]                      buf_cnt_q, buf_cnt_d;
  logic [1:0][DATA_WIDTH-1:0]      slot_q, slot_d;
  logic                            consume;

  // Binary bit i of a Gray code is the XOR of Gray bits i..MSB.
  always_comb begin
    wptr_bin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      wptr_bin[i] = ^(wq2_q >> i);
    end
  end

  assign empty    = (g_rptr == wq2_q);
  assign r_en     = !empty && (buf_cnt_q != 2'd2);
  assign consume  = m.valid && m.ready;
  assign rd_level = wptr_bin - b_rptr;

  assign m.valid  = (buf_cnt_q != 2'd0);
  assign m.data   = slot_q[0];

  assign b_rptr_d = r_en ? b_rptr + PW'(1) : b_rptr;
  assign g_rptr_d = b_rptr_d ^ (b_rptr_d >> 1);

  // Slot 0 is always the head; a pop lands at the first free slot behind it.
  always_comb begin
    slot_d    = slot_q;
    buf_cnt_d = buf_cnt_q;
    case ({r_en, consume})
      2'b10: begin
        slot_d[buf_cnt_q[0]] = mem_rdata;
        buf_cnt_d            = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        slot_d[0] = slot_q[1];
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      // Pop and consume together only happen with one word held.
      2'b11: slot_d[0] = mem_rdata;
      default: ;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      wq1_q     <= '0;
      wq2_q     <= '0;
      b_rptr    <= '0;
      g_rptr    <= '0;
      buf_cnt_q <= '0;
      slot_q    <= '0;
    end else begin
      wq1_q     <= g_wptr;
      wq2_q     <= wq1_q;
      b_rptr    <= b_rptr_d;
      g_rptr    <= g_rptr_d;
      buf_cnt_q <= buf_cnt_d;
      slot_q    <= slot_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_port.sv
// Directed bench for fifo_rd_port with a behavioural memory and writer model.
module tb_fifo_rd_port;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 4;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic [PW:0]   wptr = '0;
  logic [PW:0]   g_wptr, b_rptr, g_rptr, rd_level;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] mem_rdata;
  logic          empty, r_en;

  int            tests_run = 0;
  int            tests_failed = 0;
  logic [DW-1:0] exp_q [$];

  fifo_rd_port_if #(.DATA_WIDTH(DW)) m_if ();

  assign g_wptr    = wptr ^ (wptr >> 1);
  assign mem_rdata = mem[b_rptr[PW-1:0]];

  fifo_rd_port #(
    .DEPTH      (16),
    .DATA_WIDTH (DW),
    .PTR_WIDTH  (PW)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .g_wptr    (g_wptr),
    .mem_rdata (mem_rdata),
    .b_rptr    (b_rptr),
    .g_rptr    (g_rptr),
    .empty     (empty),
    .r_en      (r_en),
    .m         (m_if),
    .rd_level  (rd_level)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rrst_n     = 1'b0;
    wptr       = '0;
    m_if.ready = 1'b0;
    exp_q.delete();
    tick();
    rrst_n = 1'b1;
  endtask

  task automatic collect(input string tag, input int n, input int budget);
    int got = 0;
    m_if.ready = 1'b1;
    for (int c = 0; c < budget && got < n; c++) begin
      if (m_if.valid) begin
        check(tag, 32'(m_if.data), 32'(exp_q.pop_front()));
        got++;
      end
      tick();
    end
    m_if.ready = 1'b0;
    check({tag, "_count"}, 32'(got), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pops, stable_bad, got, written, wrapped, seen_valid, waitc;
    logic [PW:0]   prev_b, prev_g;
    logic [DW-1:0] wd;

    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset held two edges with a non-zero write pointer waiting.
    mem[0]     = 8'h3C;
    wptr       = 5'd2;
    m_if.ready = 1'b0;
    rrst_n     = 1'b0;
    tick(2);
    check("rst_valid", 32'(m_if.valid), 0);
    check("rst_ren", 32'(r_en), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_level", 32'(rd_level), 0);
    check("rst_brptr", 32'(b_rptr), 0);
    check("rst_grptr", 32'(g_rptr), 0);
    check("rst_data", 32'(m_if.data), 0);
    rrst_n = 1'b1;
    tick();
    check("rel_valid_e1", 32'(m_if.valid), 0);
    tick();
    check("rel_empty_e2", 32'(empty), 0);
    check("rel_level_e2", 32'(rd_level), 2);
    tick();
    check("rel_valid_e3", 32'(m_if.valid), 1);
    check("rel_data_e3", 32'(m_if.data), 32'h3C);

    // Single word.
    do_reset();
    mem[0] = 8'hA5;
    wptr   = 5'd1;
    tick(2);
    check("sw_valid_e2", 32'(m_if.valid), 0);
    check("sw_empty_e2", 32'(empty), 0);
    tick();
    check("sw_valid_e3", 32'(m_if.valid), 1);
    check("sw_data", 32'(m_if.data), 32'hA5);
    check("sw_brptr", 32'(b_rptr), 1);
    check("sw_grptr", 32'(g_rptr), 1);
    check("sw_empty", 32'(empty), 1);
    check("sw_level", 32'(rd_level), 0);
    m_if.ready = 1'b1;
    tick();
    check("sw_drained", 32'(m_if.valid), 0);
    m_if.ready = 1'b0;

    // Burst of 16 with the consumer always ready: no bubbles.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    wptr       = 5'd16;
    m_if.ready = 1'b1;
    waitc      = 0;
    while (!m_if.valid && waitc < 10) begin
      tick();
      waitc++;
    end
    check("burst_start", 32'(m_if.valid), 1);
    for (int k = 0; k < 16; k++) begin
      check("burst_valid", 32'(m_if.valid), 1);
      check("burst_data", 32'(m_if.data), 32'(k));
      tick();
    end
    check("burst_brptr", 32'(b_rptr), 16);
    check("burst_end_valid", 32'(m_if.valid), 0);
    check("burst_empty", 32'(empty), 1);
    m_if.ready = 1'b0;

    // Backpressure: only two words may leave memory while stalled.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem[i] = 8'h50 + 8'(i);
      exp_q.push_back(8'h50 + 8'(i));
    end
    wptr       = 5'd5;
    pops       = 0;
    stable_bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (r_en) pops++;
      if (m_if.valid && m_if.data != 8'h50) stable_bad++;
      tick();
    end
    check("bp_pops", 32'(pops), 2);
    check("bp_brptr", 32'(b_rptr), 2);
    check("bp_level", 32'(rd_level), 3);
    check("bp_valid", 32'(m_if.valid), 1);
    check("bp_data", 32'(m_if.data), 32'h50);
    check("bp_stable", 32'(stable_bad), 0);
    collect("bp_beat", 5, 30);

    // Wrap-around with a writer that honours full and a random consumer.
    do_reset();
    got     = 0;
    written = 0;
    wrapped = 0;
    prev_b  = b_rptr;
    prev_g  = g_rptr;
    for (int cyc = 0; cyc < 3000 && got < 40; cyc++) begin
      m_if.ready = 1'($urandom_range(0, 1));
      if (m_if.valid && m_if.ready) begin
        check("wrap_data", 32'(m_if.data), 32'(exp_q.pop_front()));
        got++;
      end
      if (written < 40 && 5'(wptr - b_rptr) < 5'd16 && $urandom_range(0, 3) != 0) begin
        wd = 8'(written * 13 + 1);
        mem[wptr[PW-1:0]] = wd;
        exp_q.push_back(wd);
        wptr = wptr + 5'd1;
        written++;
      end
      tick();
      if (g_rptr != prev_g) check("wrap_gray_step", 32'($countones(g_rptr ^ prev_g)), 1);
      if (prev_b == 5'd31 && b_rptr == 5'd0) wrapped = 1;
      prev_b = b_rptr;
      prev_g = g_rptr;
    end
    m_if.ready = 1'b0;
    check("wrap_beats", 32'(got), 40);
    check("wrap_seen", 32'(wrapped), 1);

    // Reset with both buffer slots full.
    do_reset();
    for (int i = 0; i < 6; i++) mem[i] = 8'hC0 + 8'(i);
    wptr = 5'd6;
    tick(5);
    check("mid_pre_brptr", 32'(b_rptr), 2);
    check("mid_pre_valid", 32'(m_if.valid), 1);
    rrst_n = 1'b0;
    wptr   = '0;
    tick();
    rrst_n = 1'b1;
    check("mid_valid", 32'(m_if.valid), 0);
    check("mid_brptr", 32'(b_rptr), 0);
    check("mid_empty", 32'(empty), 1);
    m_if.ready = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 6; c++) begin
      if (m_if.valid) seen_valid++;
      tick();
    end
    check("mid_no_stale", 32'(seen_valid), 0);
    mem[0] = 8'h77;
    exp_q.delete();
    exp_q.push_back(8'h77);
    wptr = 5'd1;
    collect("mid_fresh", 1, 20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_rd_port.md
# fifo_rd_port

Read-side controller for the asynchronous FIFO, living entirely in the `rclk` domain opposite the write pointer logic. It does four jobs:
- synchronises the Gray-coded write pointer;
- owns the binary and Gray read pointers;
- generates `empty`;
- prefetches words from the FIFO memory's combinational read port into a 2-entry output buffer, presented to the consumer as a valid/ready stream.

It drives the memory's `b_rptr` and consumes its `data_out`.

## Interface
- `DEPTH`, 16, number of memory entries; must equal 2^`PTR_WIDTH`.
- `DATA_WIDTH`, 8, word width.
- `PTR_WIDTH`, 4, memory address width; pointers are `PTR_WIDTH+1` bits.

Ports:
- `rclk`  in  1  read clock; the only clock.
- `rrst_n`  in  1  reset; synchronous, active-low.
- `g_wptr`  in  `PTR_WIDTH+1`  Gray write pointer from the `wclk` domain (asynchronous).
- `mem_rdata`  in  `DATA_WIDTH`  memory word at `b_rptr[PTR_WIDTH-1:0]` (combinational read).
- `b_rptr`  out  `PTR_WIDTH+1`  binary read pointer, registered.
- `g_rptr`  out  `PTR_WIDTH+1`  Gray read pointer, registered, goes to the writer's synchroniser.
- `empty`  out  1  memory holds no unread word.
- `r_en`  out  1  pop strobe this cycle.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  consumer accepts `m_data` this cycle.
- `m_data`  out  `DATA_WIDTH`  head of the output buffer.
- `rd_level`  out  `PTR_WIDTH+1`  words in memory not yet popped (0..`DEPTH`).

## Operation
- **Synchroniser:** two flops, `wq1 <= g_wptr; wq2 <= wq1`.
- **Write pointer:** `wptr_bin` is the Gray-to-binary conversion of `wq2`.
- **Empty:** `empty = (g_rptr == wq2)`, combinational from registers.
- **Buffer:** 2-entry FIFO of slots, with count `buf_cnt` in 0..2.
  - `m_valid = (buf_cnt != 0)`.
  - `m_data` = oldest slot.
- **Pop:** `r_en = !empty && (buf_cnt != 2)`. There is no path from `m_ready` to `r_en`.
- **On a pop:**
  - `mem_rdata` is written into the buffer tail.
  - `b_rptr <= b_rptr + 1`, wrapping modulo 2^(`PTR_WIDTH+1`).
  - `g_rptr <= next ^ (next >> 1)`.
- **Consume:** `m_valid && m_ready` removes the head.
- **Simultaneous pop and consume:** `buf_cnt` is unchanged, and order is preserved (the popped word goes behind the remaining word).
- **Level:** `rd_level = wptr_bin - b_rptr`, modulo 2^(`PTR_WIDTH+1`), unsigned. It excludes words already held in the buffer.
- **Wrap-around:** `b_rptr` 31→0 at default parameters. The memory index is `b_rptr[PTR_WIDTH-1:0]`. The MSB is used only for Gray comparison.
- **Consumer stall** (`m_ready`=0): holding `m_data`/`m_valid` stable is required. At most 2 words leave memory, then popping stops until a consume.
- **Reset mid-operation:** all state clears on the next `rclk` edge and buffered words are discarded. The system requires the write side to be reset together.

## Timing
- **Reset values** (after an `rclk` edge with `rrst_n`=0):
  - `wq1`, `wq2`, `b_rptr`, `g_rptr`, `buf_cnt`, slots, `m_data` = 0.
  - `m_valid` = 0, `r_en` = 0, `empty` = 1, `rd_level` = 0.
- **Write to stream latency:** with `g_wptr` changed and stable before edge 1:
  - edge 2 updates `wq2`, and `empty` falls.
  - edge 3 pops, and `m_valid` = 1 after edge 3.
- **Throughput:** with `m_ready` held 1, one word per cycle is sustained. `buf_cnt` stays at 1.
- **Stream signals:** `m_data`/`m_valid` change only on `rclk` edges.
- **Pointer updates:** `b_rptr`/`g_rptr` change on the same edge as the pop. `g_rptr` changes by exactly one bit per pop.

## Test plan
- **Reset:** hold `rrst_n`=0 for 2 edges with `g_wptr`=5'b00011.
  - All outputs must hold their reset values.
  - Release reset. `m_valid` must rise 3 edges later, and `m_data` must equal `mem[0]`.
- **Single word:** memory model `mem[0]`=8'hA5, `g_wptr` 0→1.
  - `m_valid` must rise 3 edges later with `m_data`=8'hA5.
  - Then `b_rptr`=1, `empty`=1 and `rd_level`=0.
- **Burst:** 16 words 8'h00..8'h0F with `g_wptr`=5'b11000 (binary 16) and `m_ready`=1.
  - 16 consecutive `m_valid` beats in order, with no bubbles.
  - `b_rptr` ends at 16.
- **Backpressure:** 5 words available, `m_ready`=0 for 10 cycles.
  - Exactly 2 pops occur, giving `b_rptr`=2 and `rd_level`=3, with `m_data` stable at word 0.
  - Then `m_ready`=1: 5 beats arrive in order.
- **Wrap-around:** 40 words through in windows of at most 16 (writer model honours full), with random `m_ready`.
  - Data matches in order.
  - `b_rptr` passes 31→0.
  - `g_rptr` has single-bit transitions throughout.
- **Reset mid-stream:** with `buf_cnt`=2, assert `rrst_n`=0 for 1 edge.
  - `m_valid`=0, `b_rptr`=0 and `empty`=1 on the next cycle.
  - No stale word is emitted afterwards.
